// File: rtl/portal_indication_arbiter_if.sv
// Source-side FIFO handshakes and host-side portal indication/interrupt signals.
// master = arbiter view, slave = surrounding sources and host.
interface portal_indication_arbiter_if #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 32
);
  logic [NUM_SRC-1:0]        src_notEmpty;
  logic [NUM_SRC*DATA_W-1:0] src_first;
  logic [NUM_SRC-1:0]        EN_src_deq;

  logic                      RDY_ind_first;
  logic [DATA_W-1:0]         ind_first;
  logic [15:0]               ind_methodNumber;
  logic                      RDY_ind_deq;
  logic                      EN_ind_deq;
  logic                      RDY_ind_notEmpty;
  logic                      ind_notEmpty;

  logic                      EN_intr_enable;
  logic                      intr_enable_v;
  logic                      RDY_intr_status;
  logic                      intr_status;
  logic                      RDY_intr_channel;
  logic [31:0]               intr_channel;

  modport master (
    input  src_notEmpty, src_first, EN_ind_deq, EN_intr_enable, intr_enable_v,
    output EN_src_deq, RDY_ind_first, ind_first, ind_methodNumber, RDY_ind_deq,
           RDY_ind_notEmpty, ind_notEmpty, RDY_intr_status, intr_status,
           RDY_intr_channel, intr_channel
  );

  modport slave (
    output src_notEmpty, src_first, EN_ind_deq, EN_intr_enable, intr_enable_v,
    input  EN_src_deq, RDY_ind_first, ind_first, ind_methodNumber, RDY_ind_deq,
           RDY_ind_notEmpty, ind_notEmpty, RDY_intr_status, intr_status,
           RDY_intr_channel, intr_channel
  );
endinterface

// File: rtl/portal_indication_arbiter.sv
// Round-robin merge of NUM_SRC indication sources into one tagged output FIFO
// feeding the portal first/deq/interrupt interface.
module portal_indication_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CHANNEL = 0
) (
  input logic                    CLK,
  input logic                    RST_N,
  portal_indication_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              space;
  logic              do_enq;
  logic              do_deq;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              intr_en;
  logic              not_empty;

  logic [DATA_W-1:0] src_word [NUM_SRC];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [IDX_W-1:0]  idx_mem  [DEPTH];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_word
    assign src_word[i] = bus.src_first[i*DATA_W +: DATA_W];
  end

  // First non-empty source scanning upward from rr_ptr, modulo NUM_SRC
  always_comb begin
    int unsigned cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!grant_valid && bus.src_notEmpty[IDX_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Space from registered count only, so EN_ind_deq never reaches EN_src_deq
  assign space     = (count < CNT_W'(DEPTH));
  assign do_enq    = RST_N & space & grant_valid;
  assign do_deq    = bus.EN_ind_deq & (count != '0);
  assign not_empty = (count != '0);

  always_comb begin
    bus.EN_src_deq = '0;
    if (do_enq) bus.EN_src_deq[grant_idx] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      intr_en <= 1'b0;
    end else begin
      if (do_enq) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.EN_intr_enable) intr_en <= bus.intr_enable_v;
    end
  end

  // Storage carries no reset; validity is tracked by count
  always_ff @(posedge CLK) begin
    if (do_enq) begin
      data_mem[wr_ptr] <= src_word[grant_idx];
      idx_mem[wr_ptr]  <= grant_idx;
    end
  end

  assign bus.RDY_ind_first    = not_empty;
  assign bus.ind_first        = data_mem[rd_ptr];
  assign bus.ind_methodNumber = 16'(idx_mem[rd_ptr]);
  assign bus.RDY_ind_deq      = not_empty;
  assign bus.RDY_ind_notEmpty = 1'b1;
  assign bus.ind_notEmpty     = not_empty;
  assign bus.RDY_intr_status  = 1'b1;
  assign bus.intr_status      = not_empty & intr_en;
  assign bus.RDY_intr_channel = 1'b1;
  assign bus.intr_channel     = 32'(CHANNEL);

endmodule

// File: doc/portal_indication_arbiter.md
Name: portal_indication_arbiter

Overview:
- Shares one portal indication output channel among NUM_SRC indication sources, each presenting a FIFO-style interface (notEmpty/first/deq).
- Pulls one word per cycle from the sources in round-robin order.
- Tags each word with the source index as its method number and buffers it in an internal DEPTH-entry FIFO.
- Sits between per-method indication serializers and the portal interrupt/first/deq interface seen by the host.

Parameters:
NUM_SRC, 4, number of indication sources (2..16)
DATA_W, 32, width of each indication word
DEPTH, 4, output FIFO entries (power of 2, >=2)
CHANNEL, 0, constant value driven on intr_channel

Ports:
CLK  in  1  clock
RST_N  in  1  reset, asynchronous, active-low
src_notEmpty  in  NUM_SRC  bit i: source i has a word available
src_first  in  NUM_SRC*DATA_W  word of source i at bits [i*DATA_W +: DATA_W]
EN_src_deq  out  NUM_SRC  one-hot pop strobe to source i
RDY_ind_first  out  1  output FIFO non-empty
ind_first  out  DATA_W  head word
ind_methodNumber  out  16  head source index, zero-extended
RDY_ind_deq  out  1  output FIFO non-empty
EN_ind_deq  in  1  pop head
RDY_ind_notEmpty  out  1  constant 1
ind_notEmpty  out  1  output FIFO non-empty
EN_intr_enable  in  1  write interrupt enable
intr_enable_v  in  1  new interrupt enable value
RDY_intr_status  out  1  constant 1
intr_status  out  1  ind_notEmpty & intr_en
RDY_intr_channel  out  1  constant 1
intr_channel  out  32  CHANNEL

Behaviour:
Reset (RST_N low, asynchronous):
- count=0, rd_ptr=0, wr_ptr=0, rr_ptr=0, intr_en=0.
- EN_src_deq=0; ind_notEmpty, RDY_ind_first, RDY_ind_deq and intr_status all 0.
- FIFO data contents are don't-care.
- Reset asserted mid-operation discards buffered words; no source is popped while RST_N is low.

Space:
- space = (registered count < DEPTH).
- A deq in the same cycle does NOT create space; this avoids a combinational path from EN_ind_deq to EN_src_deq.

Arbitration (combinational from registered state and src_notEmpty):
- If space and any src_notEmpty, grant g = first i with src_notEmpty[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
- EN_src_deq = one-hot(g); otherwise all zero.
- At most one source is popped per cycle.

Enqueue on grant (clock edge):
- fifo[wr_ptr] <= {g, src_first[g]}; wr_ptr++ (wraps modulo DEPTH).
- rr_ptr <= (g+1) mod NUM_SRC.
- rr_ptr is unchanged when there is no grant.

Latency:
- A word popped in cycle n appears on ind_first/ind_methodNumber, with ind_notEmpty=1, in cycle n+1 if the FIFO was empty.

Dequeue:
- EN_ind_deq while count>0 advances rd_ptr (wraps).
- EN_ind_deq while count==0 is a protocol violation: ignored, with no pointer or count change.

Simultaneous enqueue and dequeue:
- count unchanged, both pointers advance.
- Enqueue at count==DEPTH never occurs, because space is 0.

Full and sources:
- When full, EN_src_deq=0 and sources hold their data.

Output order:
- Strictly FIFO.
- Per-source order is preserved.
- Cross-source order is round-robin: no source gets a second grant while another source with notEmpty asserted at the same scan is skipped.

Interrupt:
- EN_intr_enable: intr_en <= intr_enable_v on the next edge.
- intr_status = ind_notEmpty & intr_en, combinational from registered state.

Widths:
- ind_methodNumber = {zeros, head index}.
- count is clog2(DEPTH)+1 bits.

Test Plan:
- Reset then idle: all sources empty -> EN_src_deq=0, ind_notEmpty=0 and intr_status=0 for 10 cycles; intr_channel=CHANNEL.
- Single source: source 2 supplies 0xA5A50001, popped in cycle n -> ind_first=0xA5A50001 and ind_methodNumber=2 in cycle n+1; after EN_ind_deq, ind_notEmpty=0.
- Round-robin fairness: all 4 sources continuously non-empty and host deqs every cycle -> grant sequence 0,1,2,3,0,1,... with no repeats while others wait.
- Full/backpressure: DEPTH=4, no deq -> exactly 4 pops, then EN_src_deq=0. Then one EN_ind_deq -> next pop occurs the following cycle, not the same cycle. Words drain in order.
- Interrupt and bad deq: intr_en=0 with data present -> intr_status=0; write intr_en=1 -> intr_status=1 next cycle. EN_ind_deq on an empty FIFO -> count stays 0.
- Async reset mid-stream: RST_N dropped between edges with 3 words buffered -> ind_notEmpty and EN_src_deq go 0 immediately. After release, arbitration restarts at source 0.
